// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h00400000;
  localparam logic [5:0]  OP_J             = 6'b000010;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } fetch_entry_t;

  // J-type target: region bits come from the sequential pc, low bits from the word.
  function automatic logic [31:0] jump_target(input logic [31:0] jump_pc,
                                              input logic [31:0] word);
    logic [31:0] seq_pc;
    seq_pc = jump_pc + 32'd4;
    return (seq_pc & 32'hF000_0000) | ((word << 2) & 32'h0FFF_FFFC);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory and decode.
interface instr_fetch_unit_if;

  logic        mem_read_n;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_word;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output mem_read_n, mem_addr, instr_valid, instr_word, instr_pc,
    input  mem_data, instr_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  mem_read_n, mem_addr, instr_valid, instr_word, instr_pc,
    output mem_data, instr_ready, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/fetch_queue.sv
// Small circular FIFO holding fetched {pc, word} entries toward decode.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           push,
  input  fetch_entry_t                   push_entry,
  input  logic                           pop,
  output fetch_entry_t                   head,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t    slots [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head = slots[rd_ptr];

  // Pointer and occupancy bookkeeping; flush empties the queue in one edge.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents of empty slots are never observed downstream.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) slots[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the pc, tracks the one in-flight memory read
// and feeds a small queue toward decode with redirect flush.
// Optional macro FETCH_JUMP_PREDECODE_EN: captured J words redirect the unit
// to their target without flushing the queue.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = 2
) (
  input logic                 clk,
  input logic                 rst,
  instr_fetch_unit_if.master  bus
);

  localparam int CW  = $clog2(BUF_DEPTH + 1);
  localparam int CW1 = CW + 1;

  fetch_state_t   state;
  logic [31:0]    pc;
  logic [31:0]    inflight_pc;
  logic           inflight;

  logic [CW-1:0]  count;
  logic [CW:0]    occupancy;
  fetch_entry_t   head;
  fetch_entry_t   push_entry;
  logic           valid;
  logic           pop;
  logic           push;
  logic           req;
  logic           jump_taken;
  logic [31:0]    jump_pc;

  assign valid      = (count != '0);
  assign pop        = valid && bus.instr_ready && !bus.redirect_valid;
  assign push       = inflight && !bus.redirect_valid;
  assign push_entry = '{pc: inflight_pc, word: bus.mem_data};

  // Slots already spoken for next cycle; a new request must still leave room.
  assign occupancy = {1'b0, count} + CW1'(inflight) - CW1'(pop);
  assign req       = (state == RUN) && !bus.redirect_valid &&
                     (occupancy < CW1'(BUF_DEPTH));

`ifdef FETCH_JUMP_PREDECODE_EN
  assign jump_taken = push && (bus.mem_data[31:26] == OP_J);
  assign jump_pc    = jump_target(inflight_pc, bus.mem_data);
`else
  assign jump_taken = 1'b0;
  assign jump_pc    = RESET_PC;
`endif

  assign bus.mem_read_n  = !req;
  assign bus.mem_addr    = pc;
  assign bus.instr_valid = valid;
  assign bus.instr_word  = valid ? head.word : 32'h0;
  assign bus.instr_pc    = valid ? head.pc   : 32'h0;

  fetch_queue #(
    .DEPTH (BUF_DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .flush      (bus.redirect_valid),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (count)
  );

  // Control FSM: external redirect beats a predecoded jump, which beats the
  // normal request/advance; IDLE and FLUSH are single bubble cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 32'h0;
    end else if (bus.redirect_valid) begin
      state    <= FLUSH;
      pc       <= bus.redirect_pc & 32'hFFFF_FFFC;
      inflight <= 1'b0;
    end else if (jump_taken) begin
      state    <= FLUSH;
      pc       <= jump_pc;
      inflight <= 1'b0;
    end else begin
      state    <= RUN;
      inflight <= req;
      if (req) begin
        inflight_pc <= pc;
        pc          <= pc + 32'd4;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit with a one-cycle registered memory.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

`ifdef FETCH_JUMP_PREDECODE_EN
  localparam int          STREAM_VALID = 13;
  localparam logic [31:0] HOLD_PC      = 32'h02AEAA10;
`else
  localparam int          STREAM_VALID = 15;
  localparam logic [31:0] HOLD_PC      = 32'h0040003C;
`endif

  logic clk = 1'b0;
  logic rst;
  int   compared   = 0;
  int   mismatched = 0;
  int   valid_count;
  fetch_entry_t exp_q [$];
  fetch_entry_t mon_e;

  always #5 clk = ~clk;

  instr_fetch_unit_if fif ();

  instr_fetch_unit #(
    .RESET_PC  (32'h00400000),
    .BUF_DEPTH (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (fif)
  );

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h00400030) return 32'h08ABAA84;
    if (a[31:22] == 10'h001) return a ^ 32'h02728020;
    return 32'h0;
  endfunction

  // Instruction memory: registered read, garbage when not strobed.
  always @(posedge clk) begin
    fif.mem_data <= (!fif.mem_read_n) ? memWord(fif.mem_addr) : 32'hDEADBEEF;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst_v, input logic ready_v,
                               input logic redir_v, input logic [31:0] redir_pc);
    @(posedge clk);
    #1;
    rst                = rst_v;
    fif.instr_ready    = ready_v;
    fif.redirect_valid = redir_v;
    fif.redirect_pc    = redir_pc;
  endtask

  task automatic expectOne(input logic [31:0] pc, input logic [31:0] word);
    exp_q.push_back('{pc: pc, word: word});
  endtask

  task automatic expectRange(input logic [31:0] start_pc, input int n);
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      a = start_pc + 32'(4 * i);
      exp_q.push_back('{pc: a, word: memWord(a)});
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_read_n"}, 32'(fif.mem_read_n), 32'd1);
    checkOutput({tag, "_addr"},   fif.mem_addr, 32'h00400000);
    checkOutput({tag, "_valid"},  32'(fif.instr_valid), 32'd0);
    checkOutput({tag, "_word"},   fif.instr_word, 32'h0);
    checkOutput({tag, "_pc"},     fif.instr_pc, 32'h0);
  endtask

  // Monitor: every accepted head is compared with the oldest expectation.
  always @(negedge clk) begin
    if (!rst && fif.instr_valid && fif.instr_ready && !fif.redirect_valid) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_pop: got pc %h expected none", fif.instr_pc);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("stream_pc",   fif.instr_pc,   mon_e.pc);
        checkOutput("stream_word", fif.instr_word, mon_e.word);
      end
    end
  end

  initial begin
    rst                = 1'b1;
    fif.instr_ready    = 1'b1;
    fif.redirect_valid = 1'b0;
    fif.redirect_pc    = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkReset("por");

    // Stream, backpressure, release, then a mid-stream reset.
    expectOne(32'h00400000, 32'h02328020);
    expectRange(32'h00400004, 11);
    expectOne(32'h00400030, 32'h08ABAA84);
`ifdef FETCH_JUMP_PREDECODE_EN
    expectRange(32'h02AEAA10, 4);
`else
    expectRange(32'h00400034, 6);
`endif
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("idle_read_n", 32'(fif.mem_read_n), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("first_read_n", 32'(fif.mem_read_n), 32'd0);
    checkOutput("first_addr", fif.mem_addr, 32'h00400000);
    valid_count = 0;
    for (int k = 2; k <= 17; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      if (k >= 3 && fif.instr_valid) valid_count++;
    end
    checkOutput("stream_valid_cycles", valid_count, STREAM_VALID);
    for (int k = 18; k <= 22; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("hold_pc", fif.instr_pc, HOLD_PC);
      checkOutput("hold_read_n", 32'(fif.mem_read_n), 32'd1);
    end
    for (int k = 23; k <= 26; k++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkReset("mid");
    checkOutput("phase1_left", exp_q.size(), 32'd0);

    // Redirect while 0x00400010 is in flight, then a wrap-around redirect.
    expectOne(32'h00400000, 32'h02328020);
    expectRange(32'h00400004, 2);
    expectRange(32'h00400034, 4);
    for (int k = 0; k <= 5; k++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h00400036);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("flush_empty", 32'(fif.instr_valid), 32'd0);
    checkOutput("flush_read_n", 32'(fif.mem_read_n), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("redir_read_n", 32'(fif.mem_read_n), 32'd0);
    checkOutput("redir_addr", fif.mem_addr, 32'h00400034);
    for (int k = 9; k <= 13; k++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    expectOne(32'hFFFFFFFC, 32'h0);
    expectOne(32'h00000000, 32'h0);
    expectOne(32'h00000004, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFFFFFC);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("wrap_addr_hi", fif.mem_addr, 32'hFFFFFFFC);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("wrap_addr_lo", fif.mem_addr, 32'h00000000);
    for (int k = 18; k <= 20; k++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("final_left", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction-fetch initiator that drives the instruction memory's active-low read strobe and 32-bit address, and captures the returned word.
- Owns the PC.
- Tracks the single in-flight request against the memory's one-cycle registered latency.
- Buffers fetched words in a 2-entry queue toward decode, with valid/ready backpressure and redirect (jump) flush.

Parameters:
RESET_PC, 32'h00400000, first fetch address after reset
BUF_DEPTH, 2, fetch queue entries (legal range 2..4)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
mem_read_n  out  1  memory read strobe, active-low (0 = request)
mem_addr  out  32  fetch address, sampled by memory on the same clk edge
mem_data  in  32  instruction word, valid the cycle after a request edge
instr_valid  out  1  queue head valid
instr_ready  in  1  decode accepts head this cycle
instr_word  out  32  head instruction
instr_pc  out  32  head instruction address
redirect_valid  in  1  control-flow change request
redirect_pc  in  32  new fetch address

Behaviour:
- Reset (sync, active-high; asserting rst mid-operation behaves identically):
  - mem_read_n=1, mem_addr=RESET_PC.
  - instr_valid=0, instr_word=0, instr_pc=0.
  - Queue emptied; in-flight flag cleared; state=IDLE.
- States:
  - IDLE: one cycle after reset release, no request issued; goes to RUN.
  - RUN: issues requests and captures responses.
  - FLUSH: one cycle after a redirect, no request issued; goes to RUN.
- Request rule (RUN only): mem_read_n=0 and mem_addr=pc when (count + inflight - pop) < BUF_DEPTH. Otherwise mem_read_n=1.
- Capture rule: the word on mem_data is pushed with its pc at the edge after the request edge. The pc then advances by 4; wrap 32'hFFFFFFFC -> 32'h00000000.
- Steady-state throughput is 1 instruction/cycle while instr_ready=1.
- Output: instr_valid=(count!=0); instr_word/instr_pc are the head entry. Pop occurs when instr_valid && instr_ready.
- Backpressure: instr_ready=0 holds the head stable. Requests stop before overflow; a captured response always has a free slot.
- Redirect has priority over pop, push and request in the same cycle:
  - Flush the queue and kill any in-flight response (its data is dropped).
  - pc <= {redirect_pc[31:2],2'b00}.
  - Enter FLUSH; the first request at the new pc goes out the following cycle.
- mem_data=0 (unmapped address) is a legal instruction and is queued normally.
- Simultaneous push and pop leaves count unchanged.
- Invariant: count never exceeds BUF_DEPTH.

Optional Feature:
FETCH_JUMP_PREDECODE_EN
- Defined: a captured word with opcode [31:26]=6'b000010 is still queued. The unit then redirects itself to {pc_of_jump+4[31:28], word[25:0], 2'b00}.
  - Any request issued after the jump is killed; the queue is not flushed.
  - Redirect takes 1 bubble cycle.
  - An external redirect in the same cycle wins.
- Undefined: J words pass through untouched; only redirect_valid changes the pc.

Decomposition:
- Package fetch_pkg:
  - RESET_PC default, OP_J=6'b000010.
  - State enum {IDLE, RUN, FLUSH}.
  - Queue entry struct {pc[31:0], word[31:0]}.
- Sub-module fetch_queue: a parameterized BUF_DEPTH FIFO with push/pop/flush/count.
- The top holds the FSM, pc, in-flight tracking and predecode.

Test Plan:
- Reset release: first mem_read_n=0 with mem_addr=32'h00400000 occurs 1 cycle after IDLE. First instr_valid has instr_pc=32'h00400000, instr_word=32'h02328020.
- Streaming with instr_ready=1 for 15 cycles: instr_pc increments by 4 from 32'h00400000 to 32'h00400038, one per cycle, in order and with no gaps.
- instr_ready=0 for 5 cycles mid-stream: head is held, count saturates at 2, mem_read_n=1 while full, no word lost or duplicated on release.
- redirect_pc=32'h00400036 asserted while the request for 32'h00400010 is in flight: 32'h00400010 is never presented. The next instr_pc is 32'h00400034, and the queue is empty during FLUSH.
- redirect_pc=32'hFFFFFFFC: instr_pc goes 32'hFFFFFFFC then 32'h00000000 (wrap), each word 32'h0.
- FETCH_JUMP_PREDECODE_EN: word 32'h08ABAA84 at 32'h00400030 is delivered, the next delivered instr_pc is 32'h02AEAA10, and 32'h00400034 is never delivered. Without the macro, 32'h00400034 follows.
